multicycle_control: RTL and testbench

- Main control FSM for the multicycle RV32I-subset core: lh, sh, bne, add, or, sll, andi.
- Sequences each instruction through fetch/decode/execute/memory/writeback and drives datapath enables, mux selects and the 2-bit ALUop consumed by the ALU control decoder.
- ALUop encoding: 00 = memory address (add), 01 = bne (sub), 10 = R-type (decode funct3), 11 = andi (and).
- Memory accesses use a ready handshake, so the FSM stalls on slow memory.

---
 rtl/multicycle_control.sv | 153 +++++++++++++++
 tb/tb_multicycle_control.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I-subset core (lh, sh, bne, add, or, sll, andi).
// Moore decode of the state register, except the FETCH and MEM_WRITE terms gated by mem_ready.
module multicycle_control #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       mem_ready,
  output logic [1:0] ALUop,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_source,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    R_WB      = 4'd7,
    EXEC_I    = 4'd8,
    I_WB      = 4'd9,
    BRANCH    = 4'd10,
    ILLEGAL   = 4'd11
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_e state_q, state_d;
  state_e dispatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    dispatch = ILLEGAL;
    if ((opcode == OP_LOAD || opcode == OP_STORE) && funct3 == 3'b001)
      dispatch = MEM_ADDR;
    else if (opcode == OP_RTYPE && funct7 == 7'b0000000 &&
             (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b110))
      dispatch = EXEC_R;
    else if (opcode == OP_IMM && funct3 == 3'b111)
      dispatch = EXEC_I;
    else if (opcode == OP_BRANCH && funct3 == 3'b001)
      dispatch = BRANCH;
  end

  always_comb begin
    state_d       = FETCH;
    ALUop         = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    retire        = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? DECODE : FETCH;
      end
      // PC + imm is computed here so BRANCH finds its target already in ALUOut.
      DECODE: begin
        alu_src_b = 2'b10;
        state_d   = dispatch;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = mem_ready ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = mem_ready;
        state_d   = mem_ready ? FETCH : MEM_WRITE;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        ALUop     = 2'b10;
        state_d   = R_WB;
      end
      R_WB, I_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ALUop     = 2'b11;
        state_d   = I_WB;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        ALUop         = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        retire        = 1'b1;
      end
      ILLEGAL: begin
        illegal = 1'b1;
        state_d = TRAP_ON_ILLEGAL ? ILLEGAL : FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a scoreboard of per-cycle expected
// state/output vectors, with a trapping (default) and a non-trapping instance.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        mem_ready;

  logic [1:0] ALUop, alu_src_b, ALUop0, alu_src_b0;
  logic       alu_src_a, pc_write, pc_write_cond, pc_source, ir_write, iord;
  logic       mem_read, mem_write, reg_write, mem_to_reg, retire, illegal;
  logic       alu_src_a0, pc_write0, pc_write_cond0, pc_source0, ir_write0, iord0;
  logic       mem_read0, mem_write0, reg_write0, mem_to_reg0, retire0, illegal0;
  logic [3:0] state_dbg, state_dbg0;

  int passes = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Trapping instance: main target of the scoreboard
  multicycle_control #(.TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .opcode(instr[6:0]), .funct3(instr[14:12]), .funct7(instr[31:25]),
    .mem_ready(mem_ready),
    .ALUop(ALUop), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .ir_write(ir_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .retire(retire),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  // Non-trapping instance: skips illegal instructions
  multicycle_control #(.TRAP_ON_ILLEGAL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .opcode(instr[6:0]), .funct3(instr[14:12]), .funct7(instr[31:25]),
    .mem_ready(mem_ready),
    .ALUop(ALUop0), .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0),
    .pc_write(pc_write0), .pc_write_cond(pc_write_cond0), .pc_source(pc_source0),
    .ir_write(ir_write0), .iord(iord0), .mem_read(mem_read0), .mem_write(mem_write0),
    .reg_write(reg_write0), .mem_to_reg(mem_to_reg0), .retire(retire0),
    .illegal(illegal0), .state_dbg(state_dbg0)
  );

  // {state, ALUop, srcA, srcB, pcw, pcwc, pcsrc, irw, iord, mr, mw, rw, m2r, retire, illegal}
  logic [19:0] obs;
  assign obs = {state_dbg, ALUop, alu_src_a, alu_src_b, pc_write, pc_write_cond,
                pc_source, ir_write, iord, mem_read, mem_write, reg_write,
                mem_to_reg, retire, illegal};

  localparam logic [19:0] V_FETCH_W = {4'd0,  2'b00, 1'b0, 2'b01, 11'b00000100000};
  localparam logic [19:0] V_FETCH_R = {4'd0,  2'b00, 1'b0, 2'b01, 11'b10010100000};
  localparam logic [19:0] V_DECODE  = {4'd1,  2'b00, 1'b0, 2'b10, 11'b00000000000};
  localparam logic [19:0] V_MADDR   = {4'd2,  2'b00, 1'b1, 2'b10, 11'b00000000000};
  localparam logic [19:0] V_MREAD   = {4'd3,  2'b00, 1'b0, 2'b00, 11'b00001100000};
  localparam logic [19:0] V_MWB     = {4'd4,  2'b00, 1'b0, 2'b00, 11'b00000001110};
  localparam logic [19:0] V_MWR_W   = {4'd5,  2'b00, 1'b0, 2'b00, 11'b00001010000};
  localparam logic [19:0] V_MWR_R   = {4'd5,  2'b00, 1'b0, 2'b00, 11'b00001010010};
  localparam logic [19:0] V_EXR     = {4'd6,  2'b10, 1'b1, 2'b00, 11'b00000000000};
  localparam logic [19:0] V_RWB     = {4'd7,  2'b00, 1'b0, 2'b00, 11'b00000001010};
  localparam logic [19:0] V_EXI     = {4'd8,  2'b11, 1'b1, 2'b10, 11'b00000000000};
  localparam logic [19:0] V_IWB     = {4'd9,  2'b00, 1'b0, 2'b00, 11'b00000001010};
  localparam logic [19:0] V_BR      = {4'd10, 2'b01, 1'b1, 2'b00, 11'b01100000010};
  localparam logic [19:0] V_ILL     = {4'd11, 2'b00, 1'b0, 2'b00, 11'b00000000001};

  typedef struct packed {
    logic        rdy;
    logic [19:0] v;
  } sb_t;

  sb_t sb[$];

  // Stimulus pushers: mem_ready to drive in that cycle plus the expected vector
  task automatic push(input logic rdy, input logic [19:0] v);
    sb.push_back('{rdy: rdy, v: v});
  endtask

  // mem_ready is a don't-care in states that do not wait on it
  task automatic pushx(input logic [19:0] v);
    sb.push_back('{rdy: 1'($urandom_range(0, 1)), v: v});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    instr = 32'h0000_0013;
    #3;
    checks++;
    if (obs !== V_FETCH_W)
      $display("[TB] FAIL reset_state: got %h want %h", obs, V_FETCH_W);
    else passes++;
    checks++;
    if (state_dbg0 !== 4'd0)
      $display("[TB] FAIL reset_state_dut0: got %0d want 0", state_dbg0);
    else passes++;
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    sb_t e;
    int k = 0;
    instr = 32'h0020_81B3;
    push(1'b0, V_FETCH_W); push(1'b0, V_FETCH_W); push(1'b1, V_FETCH_R);
    pushx(V_DECODE); pushx(V_EXR); pushx(V_RWB);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy; #1;
      checks++;
      if (obs !== e.v) $display("[TB] FAIL add cyc%0d: got %h want %h", k, obs, e.v);
      else passes++;
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lh();
    sb_t e;
    int k = 0;
    instr = 32'h0040_9283;
    push(1'b1, V_FETCH_R); pushx(V_DECODE); pushx(V_MADDR);
    push(1'b0, V_MREAD); push(1'b0, V_MREAD); push(1'b1, V_MREAD); pushx(V_MWB);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy; #1;
      checks++;
      if (obs !== e.v) $display("[TB] FAIL lh cyc%0d: got %h want %h", k, obs, e.v);
      else passes++;
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bne();
    sb_t e;
    int k = 0;
    instr = 32'h0020_9463;
    push(1'b1, V_FETCH_R); pushx(V_DECODE); pushx(V_BR);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy; #1;
      checks++;
      if (obs !== e.v) $display("[TB] FAIL bne cyc%0d: got %h want %h", k, obs, e.v);
      else passes++;
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    sb_t e;
    int k = 0;
    // andi, then sh whose write completes one cycle late, then or
    push(1'b1, V_FETCH_R); pushx(V_DECODE); pushx(V_EXI); pushx(V_IWB);
    push(1'b1, V_FETCH_R); pushx(V_DECODE); pushx(V_MADDR);
    push(1'b0, V_MWR_W); push(1'b1, V_MWR_R);
    push(1'b1, V_FETCH_R); pushx(V_DECODE); pushx(V_EXR); pushx(V_RWB);
    while (sb.size() > 0) begin
      if (k == 0)      instr = 32'h00F0_F213;
      else if (k == 4) instr = 32'h0020_9023;
      else if (k == 9) instr = 32'h0020_E1B3;
      e = sb.pop_front();
      mem_ready = e.rdy; #1;
      checks++;
      if (obs !== e.v) $display("[TB] FAIL b2b cyc%0d: got %h want %h", k, obs, e.v);
      else passes++;
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal(input logic [31:0] bad);
    sb_t e;
    int k = 0;
    instr = bad;
    push(1'b1, V_FETCH_R); pushx(V_DECODE);
    for (int i = 0; i < 12; i++) pushx(V_ILL);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy; #1;
      checks++;
      if (obs !== e.v) $display("[TB] FAIL illegal_%h cyc%0d: got %h want %h", bad, k, obs, e.v);
      else passes++;
      if (k == 2) begin
        checks++;
        if (illegal0 !== 1'b1) $display("[TB] FAIL skip_enter_%h: got %b want 1", bad, illegal0);
        else passes++;
      end
      if (k == 3) begin
        checks++;
        if (state_dbg0 !== 4'd0) $display("[TB] FAIL skip_fetch_%h: got %0d want 0", bad, state_dbg0);
        else passes++;
      end
      k++;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== V_FETCH_W) $display("[TB] FAIL trap_reset_%h: got %h want %h", bad, obs, V_FETCH_W);
    else passes++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    sb_t e;
    int k = 0;
    instr = 32'h0020_81B3;
    push(1'b1, V_FETCH_R); pushx(V_DECODE); pushx(V_EXR);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy; #1;
      checks++;
      if (obs !== e.v) $display("[TB] FAIL abort_pre cyc%0d: got %h want %h", k, obs, e.v);
      else passes++;
      k++;
      if (sb.size() > 0) begin @(posedge clk); #1; end
    end
    // Now inside EXEC_R, away from any edge
    mem_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== V_FETCH_W) $display("[TB] FAIL abort_async: got %h want %h", obs, V_FETCH_W);
    else passes++;
    checks++;
    if (state_dbg0 !== 4'd0) $display("[TB] FAIL abort_async_dut0: got %0d want 0", state_dbg0);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (obs !== V_FETCH_W) $display("[TB] FAIL abort_hold: got %h want %h", obs, V_FETCH_W);
    else passes++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    k = 0;
    push(1'b1, V_FETCH_R); pushx(V_DECODE); pushx(V_EXR); pushx(V_RWB); push(1'b0, V_FETCH_W);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy; #1;
      checks++;
      if (obs !== e.v) $display("[TB] FAIL abort_refetch cyc%0d: got %h want %h", k, obs, e.v);
      else passes++;
      k++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lh();
    test_bne();
    test_back_to_back();
    test_illegal(32'h4020_81B3);
    test_illegal(32'h0000_007F);
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
